filter_ctl: RTL and testbench

//  Frame sequencer in front of filter_top.
//  - Latches the frame size and issues the filter start pulse.
//  - Paces source pixels into the filter row by row, with valid/ready backpressure.
//  - Inserts a programmable idle gap between rows so the ping-pong line FIFOs can settle.
//  - Waits for the filter's done, with a watchdog, then reports frame done to the top-level control.

---
 rtl/filter_ctl_pkg.sv | 27 ++
 rtl/filter_ctl_if.sv | 14 +
 rtl/filter_ctl_pos.sv | 61 ++++++
 rtl/filter_ctl.sv | 166 ++++++++++++++++
 tb/tb_filter_ctl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_ctl_pkg.sv
// Shared types and widths for the filter frame sequencer.
package filter_ctl_pkg;

  localparam int unsigned SIZE_W_WD   = 12;
  localparam int unsigned SIZE_H_WD   = 12;
  localparam int unsigned DATA_PXL_WD = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LOAD  = 3'd2,
    ST_GAP   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [SIZE_W_WD-1:0] w;
    logic [SIZE_H_WD-1:0] h;
  } frame_cfg_t;

  // A frame with a zero dimension carries no pixels.
  function automatic logic size_valid(input frame_cfg_t c);
    return (c.w != '0) && (c.h != '0);
  endfunction

endpackage

// File: rtl/filter_ctl_if.sv
// Source pixel stream with valid/ready handshake.
//   val : pixel valid (source -> sequencer)
//   dat : pixel data  (source -> sequencer)
//   rdy : sequencer can accept a pixel this cycle
interface filter_ctl_if;
  import filter_ctl_pkg::*;

  logic                   val;
  logic [DATA_PXL_WD-1:0] dat;
  logic                   rdy;

  modport master (output val, output dat, input rdy);
  modport slave  (input val, input dat, output rdy);
endinterface

// File: rtl/filter_ctl_pos.sv
// Column/row position counter for the frame being loaded.
//   clr_i        : restart at column 0, row 0
//   adv_i        : one pixel accepted
//   w_last_i     : last column index (width-1)
//   h_last_i     : last row index (height-1)
//   cnt_w_o      : column of the next pixel
//   cnt_h_o      : row of the next pixel
//   last_col_c_o : current column is the last one
//   last_row_c_o : current row is the last one
module filter_ctl_pos
  import filter_ctl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr_i,
  input  logic                 adv_i,
  input  logic [SIZE_W_WD-1:0] w_last_i,
  input  logic [SIZE_H_WD-1:0] h_last_i,
  output logic [SIZE_W_WD-1:0] cnt_w_o,
  output logic [SIZE_H_WD-1:0] cnt_h_o,
  output logic                 last_col_c_o,
  output logic                 last_row_c_o
);

  logic [SIZE_W_WD-1:0] cnt_w_q, cnt_w_d;
  logic [SIZE_H_WD-1:0] cnt_h_q, cnt_h_d;

  assign last_col_c_o = (cnt_w_q == w_last_i);
  assign last_row_c_o = (cnt_h_q == h_last_i);

  // Row stays at its last value after the final beat: no wrap past h-1.
  always_comb begin
    cnt_w_d = cnt_w_q;
    cnt_h_d = cnt_h_q;
    if (clr_i) begin
      cnt_w_d = '0;
      cnt_h_d = '0;
    end else if (adv_i) begin
      if (last_col_c_o) begin
        cnt_w_d = '0;
        if (!last_row_c_o) cnt_h_d = cnt_h_q + SIZE_H_WD'(1);
      end else begin
        cnt_w_d = cnt_w_q + SIZE_W_WD'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_w_q <= '0;
      cnt_h_q <= '0;
    end else begin
      cnt_w_q <= cnt_w_d;
      cnt_h_q <= cnt_h_d;
    end
  end

  assign cnt_w_o = cnt_w_q;
  assign cnt_h_o = cnt_h_q;

endmodule

// File: rtl/filter_ctl.sv
// Frame sequencer in front of filter_top: latches frame size, pulses the
// filter start, paces pixels row by row with an idle gap between rows, then
// waits for filter done under a watchdog and reports frame done.
//   cfg_w_i/cfg_h_i : frame size, sampled on an accepted start_i
//   start_i         : frame start, ignored while busy
//   busy_o, done_o  : frame status; err_o sticky watchdog error
//   src             : source pixel stream (rdy drops with dst_afull_i)
//   flt_*           : filter_top start, pixel stream and done
//   cnt_w_o/cnt_h_o : next column / row index aligned with flt_val_o
module filter_ctl
  import filter_ctl_pkg::*;
#(
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TMO_WD      = 11
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [SIZE_W_WD-1:0]   cfg_w_i,
  input  logic [SIZE_H_WD-1:0]   cfg_h_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  filter_ctl_if.slave            src,
  input  logic                   dst_afull_i,
  output logic                   flt_start_o,
  output logic                   flt_val_o,
  output logic [DATA_PXL_WD-1:0] flt_dat_o,
  input  logic                   flt_done_i,
  output logic [SIZE_W_WD-1:0]   cnt_w_o,
  output logic [SIZE_H_WD-1:0]   cnt_h_o
);

  localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
  localparam int unsigned TMO_LAST = TIMEOUT_CYC - 1;

  state_e                 state_q, state_d;
  frame_cfg_t             cfg_q, cfg_d, cfg_in_c;
  logic [TMO_WD-1:0]      tmr_q, tmr_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fstart_q, fstart_d;
  logic                   fval_q, fval_d;
  logic [DATA_PXL_WD-1:0] fdat_q, fdat_d;
  logic [SIZE_H_WD-1:0]   row_q, row_d;

  logic                   src_rdy_c;
  logic                   xfer_c;
  logic                   accept_c;
  logic [SIZE_H_WD-1:0]   pos_h_c;
  logic                   last_col_c;
  logic                   last_row_c;

  assign cfg_in_c  = {cfg_w_i, cfg_h_i};
  assign src_rdy_c = (state_q == ST_LOAD) && !dst_afull_i;
  assign src.rdy   = src_rdy_c;
  assign xfer_c    = src.val && src_rdy_c;
  assign accept_c  = (state_q == ST_IDLE) && start_i && size_valid(cfg_in_c);

  filter_ctl_pos u_pos (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (accept_c),
    .adv_i        (xfer_c),
    .w_last_i     (cfg_q.w - SIZE_W_WD'(1)),
    .h_last_i     (cfg_q.h - SIZE_H_WD'(1)),
    .cnt_w_o      (cnt_w_o),
    .cnt_h_o      (pos_h_c),
    .last_col_c_o (last_col_c),
    .last_row_c_o (last_row_c)
  );

  // Next state; one timer serves both the row gap and the done watchdog.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    tmr_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (accept_c) begin
            cfg_d   = cfg_in_c;
            err_d   = 1'b0;
            state_d = ST_START;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_START: state_d = ST_LOAD;
      ST_LOAD: begin
        if (xfer_c && last_col_c) begin
          if (last_row_c)        state_d = ST_WAIT;
          else if (GAP_CYC != 0) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_q == TMO_WD'(GAP_LAST)) state_d = ST_LOAD;
        else                            tmr_d   = tmr_q + TMO_WD'(1);
      end
      ST_WAIT: begin
        // Filter done takes priority over a simultaneous timeout.
        if (flt_done_i) begin
          state_d = ST_DONE;
        end else if (tmr_q == TMO_WD'(TMO_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q + TMO_WD'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register inputs; status flags track the next state.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    fstart_d = (state_d == ST_START);
    fval_d   = xfer_c;
    fdat_d   = xfer_c ? src.dat : fdat_q;
    // Lags the position counter by one cycle so the row flips only after
    // the last beat of a row has been presented.
    row_d    = pos_h_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fstart_q <= 1'b0;
      fval_q   <= 1'b0;
      fdat_q   <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fstart_q <= fstart_d;
      fval_q   <= fval_d;
      fdat_q   <= fdat_d;
      row_q    <= row_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign flt_start_o = fstart_q;
  assign flt_val_o   = fval_q;
  assign flt_dat_o   = fdat_q;
  assign cnt_h_o     = row_q;

endmodule

// File: tb/tb_filter_ctl.sv
// Bench for filter_ctl: scoreboard of accepted beats checked on flt_val_o,
// plus per-scenario timing checks.
module tb_filter_ctl;
  import filter_ctl_pkg::*;

  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 16;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [SIZE_W_WD-1:0]   cfg_w;
  logic [SIZE_H_WD-1:0]   cfg_h;
  logic                   start, afull, flt_done;
  logic                   busy_o, done_o, err_o, flt_start_o, flt_val_o;
  logic [DATA_PXL_WD-1:0] flt_dat_o;
  logic [SIZE_W_WD-1:0]   cnt_w_o;
  logic [SIZE_H_WD-1:0]   cnt_h_o;

  filter_ctl_if src_if ();

  filter_ctl #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .TMO_WD(5)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_w_i     (cfg_w),
    .cfg_h_i     (cfg_h),
    .start_i     (start),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .src         (src_if),
    .dst_afull_i (afull),
    .flt_start_o (flt_start_o),
    .flt_val_o   (flt_val_o),
    .flt_dat_o   (flt_dat_o),
    .flt_done_i  (flt_done),
    .cnt_w_o     (cnt_w_o),
    .cnt_h_o     (cnt_h_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_PXL_WD-1:0] dat;
    logic [SIZE_H_WD-1:0]   row;
  } exp_t;

  typedef struct {
    int n_start, n_beats, n_done, busy_cyc;
    int done_cyc, last_beat_cyc, fd_cyc;
    int err_at_done, err_c1, err_after, busy_after;
    int afull_lo, afull_hi;
    int n_gaps, gap_min, gap_max;
  } obs_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [DATA_PXL_WD-1:0] dat_of(input int k);
    return DATA_PXL_WD'(k * 37 + 5);
  endfunction

  // Scoreboard consumer: every presented beat must match the oldest accepted one.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn && flt_val_o) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: unexpected beat dat=%0h", flt_dat_o);
      end else begin
        e = sb.pop_front();
        if (flt_dat_o !== e.dat) begin
          bad++;
          $display("FAIL sb_dat: got %0h exp %0h", flt_dat_o, e.dat);
        end
        total++;
        if (cnt_h_o !== e.row) begin
          bad++;
          $display("FAIL sb_row: got %0d exp %0d", cnt_h_o, e.row);
        end
      end
    end
  end

  // Runs one frame with src_val always high; collects observations only.
  task automatic drive_frame(input int w, input int h, input int stall_at,
                             input int stall_len, input int done_dly,
                             input int mid_start_at, output obs_t o);
    int   k;
    int   idle;
    logic acc;
    o = '{default: 0};
    o.done_cyc = -1; o.last_beat_cyc = -1; o.fd_cyc = -1; o.gap_min = 1000;
    k = 0; idle = 0;
    @(posedge clk); #1;
    cfg_w = SIZE_W_WD'(w); cfg_h = SIZE_H_WD'(h);
    start = 1'b1; src_if.val = 1'b1; src_if.dat = dat_of(0);
    afull = 1'b0; flt_done = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) o.err_c1 = int'(err_o);
      if (flt_start_o) o.n_start++;
      if (busy_o) o.busy_cyc++;
      if (flt_done) o.fd_cyc = cyc;
      if (afull) begin
        if (src_if.rdy) o.afull_hi++;
        else            o.afull_lo++;
      end
      if (flt_val_o) begin
        if (o.n_beats > 0 && idle > 0) begin
          o.n_gaps++;
          if (idle < o.gap_min) o.gap_min = idle;
          if (idle > o.gap_max) o.gap_max = idle;
        end
        idle = 0;
        o.n_beats++;
        if (o.n_beats == w * h) o.last_beat_cyc = cyc;
      end else if (o.n_beats > 0) begin
        idle++;
      end
      acc = src_if.val && src_if.rdy;
      if (acc) begin
        sb.push_back('{dat: src_if.dat, row: SIZE_H_WD'(k / w)});
        k++;
      end
      if (done_o) begin
        o.n_done++;
        o.done_cyc = cyc;
        o.err_at_done = int'(err_o);
        break;
      end
      @(posedge clk); #1;
      start = (cyc + 1 == mid_start_at);
      if (start) begin cfg_w = SIZE_W_WD'(2); cfg_h = SIZE_H_WD'(2); end
      src_if.dat = dat_of(k);
      afull = (cyc + 1 >= stall_at) && (cyc + 1 < stall_at + stall_len);
      flt_done = (done_dly >= 0) && (o.last_beat_cyc >= 0) &&
                 (cyc + 1 == o.last_beat_cyc + done_dly);
    end
    @(posedge clk); #1;
    start = 1'b0; afull = 1'b0; flt_done = 1'b0; src_if.val = 1'b0;
    @(negedge clk);
    o.busy_after = int'(busy_o);
    o.err_after  = int'(err_o);
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; afull = 1'b0; flt_done = 1'b0;
    cfg_w = '0; cfg_h = '0; src_if.val = 1'b0; src_if.dat = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy_o, done_o, err_o, flt_start_o, flt_val_o, src_if.rdy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b exp 000000",
               {busy_o, done_o, err_o, flt_start_o, flt_val_o, src_if.rdy});
    end
    total++;
    if ({flt_dat_o, cnt_w_o, cnt_h_o} !== '0) begin
      bad++;
      $display("FAIL reset_data: got dat=%0h w=%0d h=%0d exp 0", flt_dat_o, cnt_w_o, cnt_h_o);
    end
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: got %b exp 0", busy_o);
    end
  endtask

  task automatic test_basic();
    obs_t o;
    drive_frame(4, 3, -1, 0, 3, -1, o);
    total++; if (o.n_start !== 1) begin bad++; $display("FAIL basic_start: got %0d exp 1", o.n_start); end
    total++; if (o.n_beats !== 12) begin bad++; $display("FAIL basic_beats: got %0d exp 12", o.n_beats); end
    total++; if (o.n_gaps !== 2 || o.gap_min !== GAP || o.gap_max !== GAP) begin
      bad++; $display("FAIL basic_gaps: got n=%0d min=%0d max=%0d exp n=2 gap=%0d", o.n_gaps, o.gap_min, o.gap_max, GAP);
    end
    total++; if (o.fd_cyc < 0 || o.done_cyc !== o.fd_cyc + 1) begin
      bad++; $display("FAIL basic_done_lat: got done=%0d exp %0d", o.done_cyc, o.fd_cyc + 1);
    end
    total++; if (o.err_at_done !== 0) begin bad++; $display("FAIL basic_err: got %0d exp 0", o.err_at_done); end
    total++; if (o.busy_after !== 0) begin bad++; $display("FAIL basic_busy_after: got %0d exp 0", o.busy_after); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL basic_sb_left: got %0d exp 0", sb.size()); end
  endtask

  task automatic test_stall();
    obs_t o;
    drive_frame(4, 3, 11, 3, 2, -1, o);
    total++; if (o.afull_lo !== 3 || o.afull_hi !== 0) begin
      bad++; $display("FAIL stall_rdy: got lo=%0d hi=%0d exp lo=3 hi=0", o.afull_lo, o.afull_hi);
    end
    total++; if (o.n_beats !== 12) begin bad++; $display("FAIL stall_beats: got %0d exp 12", o.n_beats); end
    total++; if (o.n_gaps !== 3 || o.gap_min !== 3 || o.gap_max !== GAP) begin
      bad++; $display("FAIL stall_gaps: got n=%0d min=%0d max=%0d exp n=3 min=3 max=%0d", o.n_gaps, o.gap_min, o.gap_max, GAP);
    end
    total++; if (o.n_done !== 1) begin bad++; $display("FAIL stall_done: got %0d exp 1", o.n_done); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL stall_sb_left: got %0d exp 0", sb.size()); end
  endtask

  task automatic test_zero_size();
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_frame(0, 3, -1, 0, -1, -1, o);
      else        drive_frame(5, 0, -1, 0, -1, -1, o);
      total++; if (o.done_cyc !== 1) begin bad++; $display("FAIL zero_done_cyc%0d: got %0d exp 1", i, o.done_cyc); end
      total++; if (o.n_start !== 0) begin bad++; $display("FAIL zero_start%0d: got %0d exp 0", i, o.n_start); end
      total++; if (o.busy_cyc !== 1 || o.busy_after !== 0) begin
        bad++; $display("FAIL zero_busy%0d: got %0d/%0d exp 1/0", i, o.busy_cyc, o.busy_after);
      end
      total++; if (o.n_beats !== 0) begin bad++; $display("FAIL zero_beats%0d: got %0d exp 0", i, o.n_beats); end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_frame(4, 3, -1, 0, -1, -1, o);
    total++; if (o.last_beat_cyc < 0 || o.done_cyc !== o.last_beat_cyc + int'(TMO)) begin
      bad++; $display("FAIL tmo_cyc: got %0d exp %0d", o.done_cyc, o.last_beat_cyc + int'(TMO));
    end
    total++; if (o.err_at_done !== 1 || o.err_after !== 1) begin
      bad++; $display("FAIL tmo_err: got %0d/%0d exp 1/1", o.err_at_done, o.err_after);
    end
    // flt_done_i on the very cycle the watchdog expires wins.
    drive_frame(4, 3, -1, 0, int'(TMO) - 1, -1, o);
    total++; if (o.err_c1 !== 0) begin bad++; $display("FAIL tmo_err_clear: got %0d exp 0", o.err_c1); end
    total++; if (o.done_cyc !== o.last_beat_cyc + int'(TMO) || o.err_at_done !== 0) begin
      bad++; $display("FAIL tmo_tie: got done=%0d err=%0d exp done=%0d err=0", o.done_cyc, o.err_at_done, o.last_beat_cyc + int'(TMO));
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   k;
    k = 0;
    @(posedge clk); #1;
    cfg_w = SIZE_W_WD'(4); cfg_h = SIZE_H_WD'(3);
    start = 1'b1; src_if.val = 1'b1; src_if.dat = dat_of(0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (src_if.val && src_if.rdy) begin
        sb.push_back('{dat: src_if.dat, row: SIZE_H_WD'(k / 4)});
        k++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      src_if.dat = dat_of(k);
    end
    @(negedge clk);
    total++; if (cnt_w_o !== SIZE_W_WD'(2) || cnt_h_o !== SIZE_H_WD'(1)) begin
      bad++; $display("FAIL rstmid_pos: got w=%0d h=%0d exp w=2 h=1", cnt_w_o, cnt_h_o);
    end
    #2 rstn = 1'b0;
    #1;
    total++; if ({busy_o, done_o, err_o, flt_start_o, flt_val_o, src_if.rdy} !== 6'b0) begin
      bad++; $display("FAIL rstmid_flags: got %b exp 000000",
                      {busy_o, done_o, err_o, flt_start_o, flt_val_o, src_if.rdy});
    end
    total++; if ({flt_dat_o, cnt_w_o, cnt_h_o} !== '0) begin
      bad++; $display("FAIL rstmid_data: got dat=%0h w=%0d h=%0d exp 0", flt_dat_o, cnt_w_o, cnt_h_o);
    end
    sb.delete();
    src_if.val = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drive_frame(4, 3, -1, 0, 1, -1, o);
    total++; if (o.n_beats !== 12 || o.n_start !== 1 || o.n_done !== 1 || o.err_at_done !== 0) begin
      bad++; $display("FAIL rstmid_rerun: got beats=%0d start=%0d done=%0d err=%0d exp 12/1/1/0",
                      o.n_beats, o.n_start, o.n_done, o.err_at_done);
    end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL rstmid_sb_left: got %0d exp 0", sb.size()); end
  endtask

  task automatic test_start_busy();
    obs_t o;
    drive_frame(4, 3, -1, 0, 2, 3, o);
    total++; if (o.n_start !== 1) begin bad++; $display("FAIL busy_start: got %0d exp 1", o.n_start); end
    total++; if (o.n_beats !== 12 || o.n_done !== 1) begin
      bad++; $display("FAIL busy_frame: got beats=%0d done=%0d exp 12/1", o.n_beats, o.n_done);
    end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL busy_sb_left: got %0d exp 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_size();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
